// File: rtl/accel_cfg_pkg.sv
// Shared state encoding and word/address helpers for the accelerator config sequencer.
package accel_cfg_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_POLL,
    S_POLL_WAIT,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_RESP
  } seq_state_e;

  // Status words sit directly above the control words in the register map.
  function automatic int stat_base(input int n_ctrl);
    return n_ctrl;
  endfunction

  function automatic int word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/accel_cfg_sequencer_poll_timer.sv
// Poll pacing: gap down-counter between polls and saturating timeout counter.
module cfg_poll_timer
  import accel_cfg_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic clk_s,
  input  logic rst_n_s,
  input  logic to_clr_i,
  input  logic to_en_i,
  input  logic gap_load_i,
  input  logic gap_en_i,
  output logic gap_done_o,
  output logic timed_out_o
);

  // Loading POLL_GAP-1 and leaving at zero gives exactly POLL_GAP gap cycles.
  localparam logic [TMR_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? TMR_W'(POLL_GAP - 1) : '0;
  localparam logic [TMR_W-1:0] TO_MAX   = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] to_q, to_d;
  logic [TMR_W-1:0] gap_q, gap_d;

  always_comb begin
    to_d = to_q;
    if (to_clr_i) begin
      to_d = '0;
    end else if (to_en_i && (to_q < TO_MAX)) begin
      to_d = to_q + TMR_W'(1);
    end

    gap_d = gap_q;
    if (gap_load_i) begin
      gap_d = GAP_LOAD;
    end else if (gap_en_i && (gap_q != '0)) begin
      gap_d = gap_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      to_q  <= '0;
      gap_q <= '0;
    end else begin
      to_q  <= to_d;
      gap_q <= gap_d;
    end
  end

  assign gap_done_o  = (gap_q == '0);
  assign timed_out_o = (to_q >= TO_MAX);

endmodule

// File: rtl/accel_cfg_sequencer.sv
// Config-port master: writes a job's control words, polls for done (with timeout),
// reads back all status words and returns them on a valid/ready response.
//   state       | meaning
//   S_IDLE      | ready for a job command
//   S_WRITE     | writing control word cnt
//   S_POLL      | reading the done word
//   S_POLL_WAIT | registered-read turnaround; done evaluated here
//   S_GAP       | idle spacing between polls
//   S_READ      | issuing status read cnt
//   S_DRAIN     | capturing the last registered read
//   S_RESP      | holding the response until accepted
module accel_cfg_sequencer
  import accel_cfg_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int N_CTRL_WORDS  = 2,
  parameter int N_STAT_WORDS  = 4,
  parameter int ADDR_WIDTH    = $clog2(N_CTRL_WORDS + N_STAT_WORDS),
  parameter int READ_LATENCY  = 0,
  parameter int DONE_STAT_IDX = 0,
  parameter int DONE_BIT      = 0,
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                               clk_s,
  input  logic                               rst_n_s,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [N_CTRL_WORDS*DATA_WIDTH-1:0] cmd_ctrl,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [N_STAT_WORDS*DATA_WIDTH-1:0] rsp_stat,
  output logic                               rsp_timeout,
  output logic                               busy,
  output logic                               mem_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_we,
  output logic [DATA_WIDTH/8-1:0]            mem_be,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] STAT_BASE_A = ADDR_WIDTH'(stat_base(N_CTRL_WORDS));
  localparam logic [ADDR_WIDTH-1:0] POLL_ADDR   = ADDR_WIDTH'(stat_base(N_CTRL_WORDS) + DONE_STAT_IDX);
  localparam logic [ADDR_WIDTH-1:0] LAST_CTRL   = ADDR_WIDTH'(N_CTRL_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_STAT   = ADDR_WIDTH'(N_STAT_WORDS - 1);

  seq_state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]             cap_idx_q, cap_idx_d;
  logic                              cap_vld_q, cap_vld_d;
  logic                              timeout_q, timeout_d;
  logic                              init_q;
  logic [N_CTRL_WORDS*DATA_WIDTH-1:0] buf_q;
  logic [N_STAT_WORDS*DATA_WIDTH-1:0] stat_q;

  logic                  accept;
  logic                  stat_we;
  logic [ADDR_WIDTH-1:0] stat_idx;
  logic                  poll_eval;
  logic                  tmr_clr, tmr_en, gap_load, gap_en;
  logic                  gap_done, timed_out;

  cfg_poll_timer #(
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) u_poll_timer (
    .clk_s       (clk_s),
    .rst_n_s     (rst_n_s),
    .to_clr_i    (tmr_clr),
    .to_en_i     (tmr_en),
    .gap_load_i  (gap_load),
    .gap_en_i    (gap_en),
    .gap_done_o  (gap_done),
    .timed_out_o (timed_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    timeout_d = timeout_q;
    accept    = 1'b0;
    stat_we   = cap_vld_q;
    stat_idx  = cap_idx_q;
    poll_eval = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = init_q;
        if (cmd_valid && init_q) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = buf_q[word_lsb(int'(cnt_q), DATA_WIDTH) +: DATA_WIDTH];
        if (cnt_q == LAST_CTRL) begin
          cnt_d   = '0;
          tmr_clr = 1'b1;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      S_POLL: begin
        mem_en   = 1'b1;
        mem_addr = POLL_ADDR;
        tmr_en   = 1'b1;
        if (READ_LATENCY == 0) begin
          poll_eval = 1'b1;
        end else begin
          state_d = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        tmr_en    = 1'b1;
        poll_eval = 1'b1;
      end
      S_GAP: begin
        tmr_en = 1'b1;
        gap_en = 1'b1;
        if (gap_done) begin
          state_d = S_POLL;
        end
      end
      S_READ: begin
        mem_en   = 1'b1;
        mem_addr = STAT_BASE_A + cnt_q;
        // With a registered port the word arrives next cycle, overlapping the next issue.
        if (READ_LATENCY == 0) begin
          stat_we  = 1'b1;
          stat_idx = cnt_q;
        end else begin
          cap_vld_d = 1'b1;
          cap_idx_d = cnt_q;
        end
        if (cnt_q == LAST_STAT) begin
          cnt_d   = '0;
          state_d = (READ_LATENCY == 0) ? S_RESP : S_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (poll_eval) begin
      if (mem_rdata[DONE_BIT]) begin
        timeout_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_READ;
      end else if (timed_out) begin
        timeout_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_READ;
      end else if (POLL_GAP == 0) begin
        state_d = S_POLL;
      end else begin
        gap_load = 1'b1;
        state_d  = S_GAP;
      end
    end
  end

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      init_q    <= 1'b0;
      buf_q     <= '0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_idx_q <= cap_idx_d;
      cap_vld_q <= cap_vld_d;
      timeout_q <= timeout_d;
      init_q    <= 1'b1;
      if (accept) begin
        buf_q <= cmd_ctrl;
      end
      if (stat_we) begin
        stat_q[word_lsb(int'(stat_idx), DATA_WIDTH) +: DATA_WIDTH] <= mem_rdata;
      end
    end
  end

  assign rsp_stat    = stat_q;
  assign rsp_timeout = timeout_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_accel_cfg_sequencer.sv
// Directed bench for accel_cfg_sequencer: three instances cover the default,
// short-timeout (TIMEOUT=15) and registered-read (READ_LATENCY=1) configurations.
`timescale 1ns/1ps
module tb_accel_cfg_sequencer;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int NS = 4;
  localparam int AW = 3;
  localparam int BW = 2;
  localparam int ND = 3;

  localparam logic [NC*DW-1:0] CTRL_A = {16'h0302, 16'h0100};
  localparam logic [NC*DW-1:0] CTRL_B = {16'hBEEF, 16'h1234};
  localparam logic [NS*DW-1:0] STAT_A = {16'h0033, 16'h0022, 16'h0011, 16'h0001};
  localparam logic [NS*DW-1:0] STAT_T = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
  localparam logic [NS*DW-1:0] STAT_C = {16'hFFFF, 16'h5A5A, 16'hA5A5, 16'h0101};

  logic clk_s   = 1'b0;
  logic rst_n_s = 1'b0;
  always #5 clk_s = ~clk_s;

  logic            cmd_valid   [ND];
  logic            cmd_ready   [ND];
  logic [NC*DW-1:0] cmd_ctrl   [ND];
  logic            rsp_valid   [ND];
  logic            rsp_ready   [ND];
  logic [NS*DW-1:0] rsp_stat   [ND];
  logic            rsp_timeout [ND];
  logic            busy        [ND];
  logic            mem_en      [ND];
  logic [AW-1:0]   mem_addr    [ND];
  logic            mem_we      [ND];
  logic [BW-1:0]   mem_be      [ND];
  logic [DW-1:0]   mem_wdata   [ND];
  logic [DW-1:0]   stat_w      [ND][NS];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [DW-1:0] rd_comb, rd_q, rdata;
    always_comb begin
      rd_comb = '0;
      if (int'(mem_addr[g]) >= NC && int'(mem_addr[g]) < NC + NS)
        rd_comb = stat_w[g][int'(mem_addr[g]) - NC];
    end
    always_ff @(posedge clk_s) if (mem_en[g]) rd_q <= rd_comb;
    assign rdata = (g == 2) ? rd_q : rd_comb;

    accel_cfg_sequencer #(
      .READ_LATENCY (g == 2 ? 1 : 0),
      .TIMEOUT      (g == 1 ? 15 : 1023)
    ) u_dut (
      .clk_s       (clk_s),
      .rst_n_s     (rst_n_s),
      .cmd_valid   (cmd_valid[g]),
      .cmd_ready   (cmd_ready[g]),
      .cmd_ctrl    (cmd_ctrl[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_stat    (rsp_stat[g]),
      .rsp_timeout (rsp_timeout[g]),
      .busy        (busy[g]),
      .mem_en      (mem_en[g]),
      .mem_addr    (mem_addr[g]),
      .mem_we      (mem_we[g]),
      .mem_be      (mem_be[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (rdata)
    );
  end

  typedef struct { int t; int addr; int we; int be; int wdata; } acc_t;
  acc_t acc_q[$];
  int   rsp_t;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_acc(input int t, input int addr, input int we,
                                           input int be, input int wdata);
    return {16'(t), 8'(addr), 8'(we), 8'(be), 16'(wdata)};
  endfunction

  task automatic chk_acc(input int i, input int t, input int addr, input int we, input int wdata);
    acc_t e;
    e = '{default: 0};
    if (i < acc_q.size()) e = acc_q[i];
    chk($sformatf("acc%0d", i), pack_acc(e.t, e.addr, e.we, e.be, e.wdata),
        pack_acc(t, addr, we, (we != 0) ? 3 : 0, wdata));
  endtask

  task automatic chk_rsp(input int g, input logic [NS*DW-1:0] stat, input logic to, input int t);
    chk("rsp_cycle", 64'(rsp_t), 64'(t));
    chk("rsp_stat", rsp_stat[g], stat);
    chk("rsp_timeout", rsp_timeout[g], to);
  endtask

  task automatic set_stat(input int g, input logic [NS*DW-1:0] s);
    for (int k = 0; k < NS; k++) stat_w[g][k] = s[k*DW +: DW];
  endtask

  // Cycle t=0 is the accept cycle; each negedge samples the access of cycle t.
  task automatic run_job(input int g, input logic [NC*DW-1:0] ctrl, input int done_at,
                         input int stop_at, input bit keep_valid);
    acc_t e;
    acc_q.delete();
    rsp_t = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_s);
      if (t == 0) begin
        cmd_valid[g] = 1'b1;
        cmd_ctrl[g]  = ctrl;
        chk("accept_ready", cmd_ready[g], 1'b1);
      end
      if (t == 1 && !keep_valid) cmd_valid[g] = 1'b0;
      if (t == done_at) stat_w[g][0][0] = 1'b1;
      if (mem_en[g]) begin
        e.t = t; e.addr = int'(mem_addr[g]); e.we = int'(mem_we[g]);
        e.be = int'(mem_be[g]); e.wdata = int'(mem_wdata[g]);
        acc_q.push_back(e);
      end else begin
        chk("idle_port_zero", {mem_addr[g], mem_we[g], mem_be[g], mem_wdata[g]}, 64'd0);
      end
      if (rsp_valid[g]) begin
        rsp_t = t;
        break;
      end
      if (t == stop_at) break;
    end
    if (rsp_t < 0 && stop_at < 0) chk("rsp_within_budget", 64'd0, 64'd1);
  endtask

  task automatic ack(input int g);
    rsp_ready[g] = 1'b1;
    @(negedge clk_s);
    rsp_ready[g] = 1'b0;
    chk("ack_idle", {busy[g], rsp_valid[g]}, 64'd0);
  endtask

  task automatic wait_rsp(input int g);
    int n;
    n = 0;
    while (!rsp_valid[g] && n < 100) begin
      @(negedge clk_s);
      n++;
    end
    chk("wait_rsp", rsp_valid[g], 1'b1);
  endtask

  // Scenario 2 shape: two writes, one poll at t=3, four reads starting at rd_t0.
  task automatic chk_basic(input int g, input int rd_t0, input int rsp_exp);
    chk("n_acc", 64'(acc_q.size()), 64'd7);
    chk_acc(0, 1, 0, 1, 16'h0100);
    chk_acc(1, 2, 1, 1, 16'h0302);
    chk_acc(2, 3, 2, 0, 0);
    for (int k = 0; k < NS; k++) chk_acc(3 + k, rd_t0 + k, 2 + k, 0, 0);
    chk_rsp(g, STAT_A, 1'b0, rsp_exp);
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      cmd_valid[g] = 1'b0;
      cmd_ctrl[g]  = '0;
      rsp_ready[g] = 1'b0;
      set_stat(g, '0);
    end

    // 1: reset and idle
    repeat (3) @(negedge clk_s);
    for (int g = 0; g < ND; g++) begin
      chk("rst_outputs", {cmd_ready[g], busy[g], rsp_valid[g], rsp_timeout[g], mem_en[g],
                          mem_we[g], mem_be[g], mem_addr[g], mem_wdata[g]}, 64'd0);
      chk("rst_stat", rsp_stat[g], 64'd0);
    end
    rst_n_s = 1'b1;
    repeat (5) begin
      @(negedge clk_s);
      for (int g = 0; g < ND; g++) begin
        chk("idle_ready", cmd_ready[g], 1'b1);
        chk("idle_quiet", {busy[g], rsp_valid[g], mem_en[g]}, 64'd0);
      end
    end

    // 2: done on first poll
    set_stat(0, STAT_A);
    run_job(0, CTRL_A, -1, -1, 1'b0);
    chk_basic(0, 4, 8);
    ack(0);

    // 3: done raised 20 cycles after the last write (t=2)
    set_stat(0, STAT_T);
    run_job(0, CTRL_A, 22, -1, 1'b0);
    chk("t3_n_acc", 64'(acc_q.size()), 64'd11);
    chk_acc(0, 1, 0, 1, 16'h0100);
    chk_acc(1, 2, 1, 1, 16'h0302);
    for (int i = 0; i < 5; i++) chk_acc(2 + i, 3 + 5 * i, 2, 0, 0);
    for (int k = 0; k < NS; k++) chk_acc(7 + k, 24 + k, 2 + k, 0, 0);
    chk_rsp(0, STAT_A, 1'b0, 28);
    ack(0);

    // 4: timeout with done never set
    set_stat(1, STAT_T);
    run_job(1, CTRL_A, -1, -1, 1'b0);
    chk("t4_n_acc", 64'(acc_q.size()), 64'd10);
    for (int i = 0; i < 4; i++) chk_acc(2 + i, 3 + 5 * i, 2, 0, 0);
    for (int k = 0; k < NS; k++) chk_acc(6 + k, 19 + k, 2 + k, 0, 0);
    chk_rsp(1, STAT_T, 1'b1, 23);
    ack(1);

    // 5: response back-pressure with cmd_valid held high
    set_stat(0, STAT_C);
    run_job(0, CTRL_B, -1, -1, 1'b1);
    chk_rsp(0, STAT_C, 1'b0, 8);
    repeat (10) begin
      @(negedge clk_s);
      chk("t5_hold_stat", rsp_stat[0], STAT_C);
      chk("t5_hold_flags", {rsp_valid[0], cmd_ready[0], mem_en[0], busy[0]}, 64'b1001);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk_s);
    rsp_ready[0] = 1'b0;
    cmd_ctrl[0]  = CTRL_A;
    chk("t5_back_idle", {busy[0], cmd_ready[0], rsp_valid[0]}, 64'b010);
    @(negedge clk_s);
    cmd_valid[0] = 1'b0;
    chk("t5_next_write", {busy[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]},
        {1'b1, 1'b1, 1'b1, 3'd0, 16'h0100});
    wait_rsp(0);
    chk("t5_next_stat", rsp_stat[0], STAT_C);
    ack(0);

    // 6: registered read port
    set_stat(2, STAT_A);
    run_job(2, CTRL_A, -1, -1, 1'b0);
    chk_basic(2, 5, 10);
    ack(2);

    // 6b: reset during GAP, then a clean job
    set_stat(2, STAT_T);
    run_job(2, CTRL_B, -1, 6, 1'b0);
    chk("t6_gap_busy", {busy[2], mem_en[2]}, 64'b10);
    chk("t6_gap_acc", 64'(acc_q.size()), 64'd3);
    rst_n_s = 1'b0;
    #1;
    chk("t6_rst_outputs", {cmd_ready[2], busy[2], rsp_valid[2], rsp_timeout[2], mem_en[2],
                           mem_we[2], mem_be[2], mem_addr[2], mem_wdata[2]}, 64'd0);
    chk("t6_rst_stat", rsp_stat[2], 64'd0);
    @(negedge clk_s);
    chk("t6_rst_hold", {busy[2], mem_en[2]}, 64'd0);
    rst_n_s = 1'b1;
    set_stat(2, STAT_A);
    run_job(2, CTRL_A, -1, -1, 1'b0);
    chk_basic(2, 5, 10);
    ack(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/accel_cfg_sequencer.md
Name: accel_cfg_sequencer

Overview:
Master-side sequencer for the accelerator configuration register port (en/addr/we/be/wdata/rdata).
- Accepts one job command holding all control words and writes them to the control region.
- Polls a done bit in the status region, with a timeout, then reads back every status word.
- Returns the status words on a valid/ready response channel. Sits between the core-side command interface and config_reg.

Parameters:
DATA_WIDTH, 16, width of one config word (multiple of 8)
N_CTRL_WORDS, 2, number of control words (addresses 0..N_CTRL_WORDS-1), >=1
N_STAT_WORDS, 4, number of status words (addresses N_CTRL_WORDS..N_CTRL_WORDS+N_STAT_WORDS-1), >=1
ADDR_WIDTH, $clog2(N_CTRL_WORDS+N_STAT_WORDS), config port address width
READ_LATENCY, 0, 0 = rdata valid in the same cycle as en; 1 = rdata valid the cycle after en
DONE_STAT_IDX, 0, index of the status word that holds the done bit
DONE_BIT, 0, bit position of done inside that word
POLL_GAP, 4, idle cycles between consecutive polls
TIMEOUT, 1023, maximum cycles spent polling before aborting (16-bit counter)

Ports:
clk_s  in  1  clock
rst_n_s  in  1  asynchronous active-low reset
cmd_valid  in  1  job request
cmd_ready  out  1  sequencer can accept a job
cmd_ctrl  in  N_CTRL_WORDS*DATA_WIDTH  control words; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_stat  out  N_STAT_WORDS*DATA_WIDTH  captured status words, same packing as cmd_ctrl
rsp_timeout  out  1  job ended by timeout, not by done
busy  out  1  FSM not in IDLE
mem_en  out  1  config port enable
mem_addr  out  ADDR_WIDTH  config port address
mem_we  out  1  write enable
mem_be  out  DATA_WIDTH/8  byte enables
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, rst_n_s=0): FSM to IDLE; counters, ctrl buffer, rsp_stat and rsp_timeout cleared to 0.
- Port outputs during and after reset: mem_en/mem_we/mem_be/mem_addr/mem_wdata all 0, rsp_valid=0, busy=0. cmd_ready=1 in IDLE once out of reset.
- Reset mid-job abandons the job; no further port access occurs.
- Outside active access cycles, mem_* are driven 0.
- States: IDLE, WRITE, POLL, POLL_WAIT, GAP, READ, DRAIN, RESP.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, capture cmd_ctrl into the internal buffer, clear word counter, go to WRITE. cmd_valid is ignored in every other state.
- WRITE: one word per cycle, mem_en=1, mem_we=1, mem_be='1, mem_addr=cnt, mem_wdata=buf[cnt]. After word N_CTRL_WORDS-1, go to POLL with the timeout counter cleared.
- Timeout counter: increments every cycle spent in POLL/POLL_WAIT/GAP, saturates at TIMEOUT.
- POLL: mem_en=1, mem_we=0, mem_be=0, mem_addr=N_CTRL_WORDS+DONE_STAT_IDX.
  - READ_LATENCY=0: evaluate mem_rdata[DONE_BIT] in the same cycle.
  - READ_LATENCY=1: go to POLL_WAIT (mem_en=0) and evaluate there.
- Poll evaluation:
  - done=1 -> READ, rsp_timeout=0.
  - Else if timeout counter >= TIMEOUT -> READ, rsp_timeout=1. The status words are still read back.
  - Else -> GAP for exactly POLL_GAP cycles, then POLL. POLL_GAP=0 means polling back-to-back.
- READ: issue word cnt at address N_CTRL_WORDS+cnt, one per cycle.
  - Latency 0: capture the word in the same cycle.
  - Latency 1: capture the word in the following cycle, which is pipelined with the next issue. After the last issue, enter DRAIN for one cycle to capture the final word.
  - Then go to RESP.
- RESP: rsp_valid=1; rsp_stat/rsp_timeout held stable until rsp_valid&rsp_ready, then IDLE. rsp_valid may remain high indefinitely.
- Write and poll/read never overlap; exactly one port access per active cycle.
- Minimum job length, latency 0, done on first poll: accept cycle + N_CTRL_WORDS + 1 + N_STAT_WORDS cycles to rsp_valid.

Decomposition:
- Package accel_cfg_pkg: seq_state_e enum, the address-base constants STAT_BASE=N_CTRL_WORDS helper function, and the packed-word slice helper.
- One sub-module is natural: cfg_poll_timer, holding the gap down-counter and the saturating timeout counter, with clear/enable inputs and gap_done/timed_out outputs.

Test Plan:
1. Reset, then idle 5 cycles -> cmd_ready=1, busy=0, rsp_valid=0, mem_en=0 every cycle.
2. Defaults, real config_reg (ASYNC_READ=1), stat words 0x0001,0x0011,0x0022,0x0033; cmd_ctrl words 0x0100,0x0302.
   - Port sees writes addr0=0x0100, addr1=0x0302, then one poll at addr2, then reads addr2..5.
   - rsp_valid rises 8 cycles after accept, rsp_stat = those four words, rsp_timeout=0.
3. Done bit raised 20 cycles after the last write -> polls at addr2 spaced exactly 5 cycles apart; no poll after done is seen; rsp_timeout=0.
4. TIMEOUT=15, done never set -> polls at cycles 0,5,10,15 of polling, then readback; rsp_timeout=1.
5. rsp_ready held low 10 cycles and cmd_valid high throughout -> rsp_stat stable, cmd_ready=0, no mem_en. After rsp_ready=1 for 1 cycle -> IDLE, and the next job is accepted the following cycle.
6. READ_LATENCY=1 run of scenario 2 -> identical rsp_stat, with one extra POLL_WAIT and one DRAIN cycle.
   - Assert rst_n_s mid-GAP -> all outputs 0 immediately, and the next job runs cleanly.
